// File: rtl/fib_engine.sv
// fib_engine -- iterative Fibonacci-style recurrence engine.
//
// A job is started from IDLE by r_enable. It loads (a, b, cnt) from
// (init_a, init_b, init_n) and then runs cnt steps of
//   a <= a + b ; b <= a
// After the last step, the final value of a is latched into result, and
// w_enable pulses for one cycle.
//
// Optional feature (compile-time macro FIB_ENGINE_MOD_EN):
//   Adds the modulus input. Each step is reduced modulo m with a single
//   conditional subtract, which is exact because a and b are both below m.
//   In this build ovf never sets.
//
// Ports
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset
//   r_enable  : start request, only looked at in IDLE
//   stall     : freezes the iteration for one cycle while in RUN
//   init_n    : iteration count
//   init_a/b  : initial a and b
//   modulus   : reduction modulus (FIB_ENGINE_MOD_EN only)
//   w_enable  : one-cycle done pulse; result is valid from then on
//   result    : final a of the most recent completed job
//   busy      : high in RUN and DONE
//   ovf       : sticky carry-out of any step in the current job
module fib_engine #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r_enable,
  input  logic              stall,
  input  logic [CNT_W-1:0]  init_n,
  input  logic [DATA_W-1:0] init_a,
  input  logic [DATA_W-1:0] init_b,
`ifdef FIB_ENGINE_MOD_EN
  input  logic [DATA_W-1:0] modulus,
`endif
  output logic              w_enable,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [CNT_W-1:0]  cnt;

  // One step of the recurrence, computed with a carry bit.
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] step_a;
  logic              step_carry;

`ifdef FIB_ENGINE_MOD_EN
  logic [DATA_W-1:0] m;
  logic [DATA_W:0]   diff;

  // Operands are both below m, so s < 2m. One conditional subtract
  // therefore fully reduces s.
  always_comb begin
    sum        = {1'b0, a} + {1'b0, b};
    diff       = sum - {1'b0, m};
    step_a     = sum[DATA_W-1:0];
    step_carry = 1'b0;
    if (sum >= {1'b0, m}) step_a = diff[DATA_W-1:0];
  end
`else
  always_comb begin
    sum        = {1'b0, a} + {1'b0, b};
    step_a     = sum[DATA_W-1:0];
    step_carry = sum[DATA_W];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      cnt      <= '0;
      result   <= '0;
      w_enable <= 1'b0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
`ifdef FIB_ENGINE_MOD_EN
      m        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          w_enable <= 1'b0;
          if (r_enable) begin
            a     <= init_a;
            b     <= init_b;
            cnt   <= init_n;
`ifdef FIB_ENGINE_MOD_EN
            m     <= modulus;
`endif
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Completion takes priority over stall. A stalled final cycle
          // would only add latency and gain nothing.
          if (cnt == '0) begin
            result   <= a;
            w_enable <= 1'b1;
            state    <= DONE;
          end else if (!stall) begin
            a   <= step_a;
            b   <= a;
            cnt <= cnt - CNT_W'(1);
            if (step_carry) ovf <= 1'b1;
          end
        end
        DONE: begin
          // r_enable is ignored here. A request still held on the next
          // cycle is picked up from IDLE.
          w_enable <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          w_enable <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
